conv_window_scheduler: RTL

//  Sequences 1-D convolution over one input row for N filters. Generates data and filter

---
 rtl/conv_window_scheduler_pkg.sv | 23 ++
 rtl/conv_window_scheduler_if.sv | 38 +++
 rtl/conv_window_scheduler_tap_counter.sv | 27 ++
 rtl/conv_window_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/conv_window_scheduler_pkg.sv
// Shared types for the 1-D convolution window scheduler: FSM states, default widths
// and the latched run configuration.
package conv_sched_pkg;

  localparam int DAW_D = 4;
  localparam int FAW_D = 6;
  localparam int SW_D  = 4;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    RUN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [SW_D-1:0]  stride;
    logic [SW_D-1:0]  fsize;
    logic [DAW_D:0]   rowlen;
    logic [SW_D-1:0]  nfilt;
  } sched_cfg_t;

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Step bus from the scheduler to the PE datapath: scratchpad addresses plus boundary
// flags, qualified by a valid/ready handshake.
interface conv_window_scheduler_if
  import conv_sched_pkg::*;
#(
  parameter int DAW = DAW_D,
  parameter int FAW = FAW_D
);

  logic           step_valid;
  logic           step_ready;
  logic [DAW-1:0] data_addr;
  logic [FAW-1:0] filt_addr;
  logic           last_tap;
  logic           end_of_row;
  logic           end_of_filt;

  modport master (
    output step_valid,
    output data_addr,
    output filt_addr,
    output last_tap,
    output end_of_row,
    output end_of_filt,
    input  step_ready
  );

  modport slave (
    input  step_valid,
    input  data_addr,
    input  filt_addr,
    input  last_tap,
    input  end_of_row,
    input  end_of_filt,
    output step_ready
  );

endinterface

// File: rtl/conv_window_scheduler_tap_counter.sv
// Loadable up-counter that wraps to zero after reaching a run-time terminal value;
// tc flags the terminal count so the caller can chain the next level.
module sched_tap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Sequences tap/window/filter steps of a 1-D convolution over one row.
// Build option PERF_CNT_EN adds a saturating stall-cycle counter on stall_cnt.
module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int DAW = DAW_D,
  parameter int FAW = FAW_D,
  parameter int SW  = SW_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SW-1:0]         cfg_stride,
  input  logic [SW-1:0]         cfg_fsize,
  input  logic [DAW:0]          cfg_rowlen,
  input  logic [SW-1:0]         cfg_nfilt,
  conv_window_scheduler_if.master step,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [15:0]           stall_cnt
);

  // Wide enough for window_base + stride + fsize without overflow.
  localparam int NW = DAW + SW + 2;

  sched_state_t   state;
  sched_cfg_t     cfg_q;
  logic           sv_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;
  logic [DAW-1:0] w;
  logic [FAW-1:0] fb;
  logic [SW-1:0]  k;
  logic [SW-1:0]  f;
  logic           k_tc;
  logic           f_tc;
  logic           launch;
  logic           accept;
  logic           last_win;
  logic           f_en;
  logic           eof_step;
  logic [NW-1:0]  win_next;
  logic [FAW-1:0] fb_next;
  logic [DAW-1:0] data_sum;
  logic [FAW-1:0] filt_sum;

  function automatic logic cfg_legal(input sched_cfg_t c);
    logic [31:0] fs;
    logic [31:0] st;
    logic [31:0] rl;
    logic [31:0] nf;
    fs = 32'(c.fsize);
    st = 32'(c.stride);
    rl = 32'(c.rowlen);
    nf = 32'(c.nfilt);
    return (fs != 0) && (st != 0) && (nf != 0) && (fs <= rl) &&
           (rl <= (32'd1 << DAW)) && ((nf * fs) <= (32'd1 << FAW));
  endfunction

  assign launch   = (state == IDLE) && start;
  assign accept   = sv_q && step.step_ready;
  assign win_next = NW'(w) + NW'(cfg_q.stride);
  assign last_win = (win_next + NW'(cfg_q.fsize)) > NW'(cfg_q.rowlen);
  assign fb_next  = fb + FAW'(cfg_q.fsize);
  assign data_sum = w + DAW'(k);
  assign filt_sum = fb + FAW'(k);
  assign f_en     = accept && k_tc && last_win;
  assign eof_step = k_tc && last_win && f_tc;

  always_ff @(posedge clk) begin
    if (launch) begin
      cfg_q <= '{stride: cfg_stride, fsize: cfg_fsize, rowlen: cfg_rowlen, nfilt: cfg_nfilt};
    end
  end

  sched_tap_counter #(.W(SW)) u_tap_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .en   (accept),
    .term (SW'(cfg_q.fsize - SW_D'(1))),
    .cnt  (k),
    .tc   (k_tc)
  );

  sched_tap_counter #(.W(SW)) u_filt_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (launch),
    .en   (f_en),
    .term (SW'(cfg_q.nfilt - SW_D'(1))),
    .cnt  (f),
    .tc   (f_tc)
  );

  // Window base and filter base advance only when a window's last tap is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w  <= '0;
      fb <= '0;
    end else if (launch) begin
      w  <= '0;
      fb <= '0;
    end else if (accept && k_tc) begin
      if (!last_win) begin
        w <= win_next[DAW-1:0];
      end else begin
        w  <= '0;
        fb <= fb_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= CHECK;
            busy_q <= 1'b1;
          end
        end
        CHECK: begin
          if (cfg_legal(cfg_q)) begin
            state <= RUN;
            sv_q  <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && eof_step) begin
            state  <= DONE;
            sv_q   <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign step.step_valid  = sv_q;
  assign step.data_addr   = sv_q ? data_sum : '0;
  assign step.filt_addr   = sv_q ? filt_sum : '0;
  assign step.last_tap    = sv_q && k_tc;
  assign step.end_of_row  = sv_q && k_tc && last_win;
  assign step.end_of_filt = sv_q && eof_step;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cfg_err          = err_q;

`ifdef PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (launch) begin
      stall_q <= '0;
    end else if ((state == RUN) && sv_q && !step.step_ready) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule
